// File: rtl/snake_pkg.sv
// Shared direction codes and helpers for the snake game input path.
package snake_pkg;

   localparam int unsigned DIR_W   = 2;
   localparam int unsigned NUM_DIR = 4;

   typedef enum logic [DIR_W-1:0] {
      DIR_RIGHT = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_DOWN  = 2'd3
   } dir_e;

   localparam logic [NUM_DIR-1:0] PUSH_IDLE = 4'b1111;

   function automatic dir_e dir_opposite(input dir_e d);
      return dir_e'(d ^ 2'b10);
   endfunction

   // Active-low one-hot button image of a direction code.
   function automatic logic [NUM_DIR-1:0] dir_push(input dir_e d);
      return ~(NUM_DIR'(4'b0001) << d);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, stable-count debouncer and registered
// press pulse on a debounced high-to-low transition.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic Clk,
   input  logic Rst,
   input  logic btn,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_1;
   logic             sync_2;
   logic             level_d;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         sync_1  <= 1'b1;
         sync_2  <= 1'b1;
         level   <= 1'b1;
         level_d <= 1'b1;
         press   <= 1'b0;
         cnt     <= '0;
      end else begin
         sync_1  <= btn;
         sync_2  <= sync_1;
         level_d <= level;
         press   <= level_d & ~level;
         // Counter only runs while the synchronised input disagrees.
         if (sync_2 == level) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            level <= sync_2;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/snake_input_ctrl.sv
// Snake game button front end: debounces the buttons, arbitrates direction
// presses with reversal rejection and toggles the pause latch.
module snake_input_ctrl
   import snake_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic [3:0]       i_Btn,
   input  logic             i_PauseBtn,
   output logic [3:0]       o_Push,
   output logic             o_Pause,
   output logic [DIR_W-1:0] o_Dir,
   output logic             o_DirValid,
   output logic             o_Reject
);

   logic [NUM_DIR-1:0] dir_level;
   logic [NUM_DIR-1:0] dir_press;
   logic               pause_level;
   logic               pause_press;

   for (genvar i = 0; i < NUM_DIR; i++) begin : g_dir
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_deb (
         .Clk   (Clk),
         .Rst   (Rst),
         .btn   (i_Btn[i]),
         .level (dir_level[i]),
         .press (dir_press[i])
      );
   end

   btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_pause_deb (
      .Clk   (Clk),
      .Rst   (Rst),
      .btn   (i_PauseBtn),
      .level (pause_level),
      .press (pause_press)
   );

   dir_e               dir_q;
   logic               armed_q;
   logic [NUM_DIR-1:0] dir_evt_c;
   logic               pause_evt_c;
   logic               dir_any_c;
   dir_e               win_c;
   logic               reject_c;

   // Qualify events with the held level; lowest index wins a tie.
   always_comb begin
      dir_evt_c   = dir_press & ~dir_level;
      pause_evt_c = pause_press & ~pause_level;
      dir_any_c   = |dir_evt_c;
      win_c       = DIR_RIGHT;
      for (int i = NUM_DIR - 1; i >= 0; i--) begin
         if (dir_evt_c[i]) win_c = dir_e'(DIR_W'(i));
      end
      // While unarmed dir_q is still right, so only left is refused.
      reject_c = (win_c == dir_opposite(dir_q)) || (armed_q && (win_c == dir_q));
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         dir_q      <= DIR_RIGHT;
         armed_q    <= 1'b0;
         o_Push     <= PUSH_IDLE;
         o_Pause    <= 1'b0;
         o_DirValid <= 1'b0;
         o_Reject   <= 1'b0;
      end else begin
         o_DirValid <= 1'b0;
         o_Reject   <= 1'b0;
         if (dir_any_c) begin
            if (reject_c) begin
               o_Reject <= 1'b1;
            end else begin
               dir_q      <= win_c;
               o_Push     <= dir_push(win_c);
               armed_q    <= 1'b1;
               o_DirValid <= 1'b1;
            end
         end
         if (pause_evt_c) o_Pause <= ~o_Pause;
      end
   end

   assign o_Dir = dir_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// Directed bench for snake_input_ctrl with DEBOUNCE_CYCLES = 4, 20 ns clock.
module tb_snake_input_ctrl;

   logic       Clk;
   logic       Rst;
   logic [3:0] i_Btn;
   logic       i_PauseBtn;
   logic [3:0] o_Push;
   logic       o_Pause;
   logic [1:0] o_Dir;
   logic       o_DirValid;
   logic       o_Reject;

   int vectors     = 0;
   int miscompares = 0;
   int dv_cnt, rj_cnt, both_cnt, dv_first;

   snake_input_ctrl #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (3)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .i_Btn      (i_Btn),
      .i_PauseBtn (i_PauseBtn),
      .o_Push     (o_Push),
      .o_Pause    (o_Pause),
      .o_Dir      (o_Dir),
      .o_DirValid (o_DirValid),
      .o_Reject   (o_Reject)
   );

   initial Clk = 1'b0;
   always #10 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      dv_cnt = 0; rj_cnt = 0; both_cnt = 0; dv_first = 0;
   endtask

   // Advance n edges, sampling 1 ns after each; k counts edges from the call.
   task automatic run(input int n);
      for (int k = 1; k <= n; k++) begin
         @(posedge Clk); #1;
         if (o_DirValid) begin
            dv_cnt++;
            if (dv_first == 0) dv_first = k;
         end
         if (o_Reject) rj_cnt++;
         if (o_DirValid && o_Reject) both_cnt++;
      end
   endtask

   initial begin
      Rst = 1'b0; i_Btn = 4'hF; i_PauseBtn = 1'b1;
      clr(); run(3);
      check("rst_push",   32'(o_Push),     32'hF);
      check("rst_pause",  32'(o_Pause),    32'h0);
      check("rst_dir",    32'(o_Dir),      32'h0);
      check("rst_dv",     32'(o_DirValid), 32'h0);
      check("rst_rj",     32'(o_Reject),   32'h0);

      Rst = 1'b1; clr(); run(50);
      check("idle_dv",    32'(dv_cnt),     32'd0);
      check("idle_rj",    32'(rj_cnt),     32'd0);
      check("idle_push",  32'(o_Push),     32'hF);

      // Clean press of up: output at edge index 7, i.e. the 8th edge after the change.
      i_Btn = 4'b1101; clr(); run(20);
      check("up_dv_cnt",  32'(dv_cnt),     32'd1);
      check("up_latency", 32'(dv_first),   32'd8);
      check("up_dir",     32'(o_Dir),      32'd1);
      check("up_push",    32'(o_Push),     32'hD);
      i_Btn = 4'hF; clr(); run(10);
      check("up_rel_dv",  32'(dv_cnt + rj_cnt), 32'd0);

      // Left bouncing every 2 cycles never settles for 4.
      clr();
      for (int b = 0; b < 10; b++) begin
         i_Btn[2] = ~i_Btn[2];
         run(2);
      end
      i_Btn[2] = 1'b1; run(10);
      check("bnc_dv",     32'(dv_cnt),     32'd0);
      check("bnc_rj",     32'(rj_cnt),     32'd0);
      check("bnc_dir",    32'(o_Dir),      32'd1);
      check("bnc_push",   32'(o_Push),     32'hD);

      // Down from up is a reversal.
      i_Btn = 4'b0111; clr(); run(10);
      check("rev_rj",     32'(rj_cnt),     32'd1);
      check("rev_dv",     32'(dv_cnt),     32'd0);
      check("rev_dir",    32'(o_Dir),      32'd1);
      i_Btn = 4'hF; run(10);
      i_Btn = 4'b1110; clr(); run(10);
      check("right_dv",   32'(dv_cnt),     32'd1);
      check("right_dir",  32'(o_Dir),      32'd0);
      check("right_push", 32'(o_Push),     32'hE);
      i_Btn = 4'hF; run(10);

      // Up and down together from right: up has the lower index.
      i_Btn = 4'b0101; clr(); run(10);
      check("sim_dv",     32'(dv_cnt),     32'd1);
      check("sim_rj",     32'(rj_cnt),     32'd0);
      check("sim_dir",    32'(o_Dir),      32'd1);
      check("sim_push",   32'(o_Push),     32'hD);
      i_Btn = 4'hF; run(10);

      // Repeat of current direction is refused.
      i_Btn = 4'b1101; clr(); run(10);
      check("rep_rj",     32'(rj_cnt),     32'd1);
      check("rep_dv",     32'(dv_cnt),     32'd0);
      i_Btn = 4'hF; run(10);

      // Pause toggles on each press.
      i_PauseBtn = 1'b0; clr(); run(10);
      i_PauseBtn = 1'b1; run(10);
      check("pause_on",   32'(o_Pause),    32'd1);
      i_PauseBtn = 1'b0; run(10);
      i_PauseBtn = 1'b1; run(10);
      check("pause_off",  32'(o_Pause),    32'd0);
      check("pause_nodir",32'(dv_cnt + rj_cnt), 32'd0);
      check("both_never", 32'(both_cnt),   32'd0);

      // Reset asserted two cycles into a right-press count.
      i_Btn = 4'b1110; run(4);
      Rst = 1'b0; #1;
      check("mid_rst_dir",  32'(o_Dir),      32'd0);
      check("mid_rst_push", 32'(o_Push),     32'hF);
      check("mid_rst_pause",32'(o_Pause),    32'd0);
      i_Btn = 4'hF; run(2);
      Rst = 1'b1; clr(); run(20);
      check("post_rst_ev",  32'(dv_cnt + rj_cnt), 32'd0);
      check("post_rst_push",32'(o_Push),     32'hF);

      // Unarmed: left is refused, right is accepted and arms.
      i_Btn = 4'b1011; clr(); run(10);
      check("unarm_left_rj",  32'(rj_cnt),   32'd1);
      check("unarm_left_dv",  32'(dv_cnt),   32'd0);
      check("unarm_left_push",32'(o_Push),   32'hF);
      i_Btn = 4'hF; run(10);
      i_Btn = 4'b1110; clr(); run(10);
      check("unarm_right_dv", 32'(dv_cnt),   32'd1);
      check("unarm_right_push",32'(o_Push),  32'hE);
      i_Btn = 4'hF; run(10);
      // Now armed at right: right again is a repeat.
      i_Btn = 4'b1110; clr(); run(10);
      check("armed_right_rj", 32'(rj_cnt),   32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
